pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised, elastic successor to the fixed MEM/WB-style pipeline registers.
- Carries a generic WIDTH-bit payload (packed control plus data fields) through DEPTH register stages.
- Each stage has a valid bit, a valid/ready handshake with bubble collapse, and a synchronous flush for hazard and branch squash.
- Sits between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). The caller packs and unpacks the fields.

Parameters:
- WIDTH, 32, payload bits per stage (1..256).
- DEPTH, 1, number of register stages (1..4).
- RESET_DATA, 0, value loaded into every stage's data register on Reset.

Ports:
- Clk  in  1  clock; all state updates on posedge only.
- Reset  in  1  asynchronous, active-high reset.
- InValid  in  1  upstream presents a valid payload.
- InReady  out  1  stage 0 can accept this cycle.
- InData  in  WIDTH  upstream payload.
- Flush  in  1  squash all in-flight entries (synchronous).
- OutValid  out  1  last stage holds a valid payload.
- OutReady  in  1  downstream accepts this cycle.
- OutData  out  WIDTH  last-stage payload.
- Occupancy  out  3  count of valid stages (0..DEPTH).
- StallCount  out  32  performance counter (see Optional Feature).

Behaviour:
- State per stage i (0..DEPTH-1): V[i] and D[i]. Stage DEPTH-1 drives OutValid and OutData directly from registers; there is no combinational path from InData.
- Advance rule:
  - adv[DEPTH-1] = OutReady || !V[DEPTH-1].
  - adv[i] = adv[i+1] || !V[i].
  - InReady = adv[0].
- Bubble collapse: an empty stage accepts from its predecessor even while later stages are stalled.
- Ready is a combinational chain from OutReady to InReady, DEPTH gates deep. This is accepted at DEPTH ≤ 4.
- Transfer on posedge when adv[i] is high:
  - V[i] <= V[i-1] and D[i] <= D[i-1], where stage -1 is InValid/InData.
  - When adv[i] is low, the stage holds.
  - D[i] loads only when the incoming valid is 1; it holds otherwise, which saves toggling.
- Latency: an accepted word appears on OutValid exactly DEPTH cycles after acceptance when OutReady is held high.
- Throughput: 1 word/cycle with no bubbles.
- Stall: while OutReady=0 and V[DEPTH-1]=1:
  - OutData is stable.
  - OutValid stays 1.
  - Upstream stages fill, then InReady drops.
- Flush:
  - On a posedge with Flush=1, all V[i] <= 0.
  - The input word presented that cycle is NOT captured, even if InValid=1.
  - D[i] is unchanged.
  - InReady stays computed normally so upstream sees a consumed handshake. Squashed words are discarded.
  - Flush has priority over every transfer.
- Occupancy: registered popcount of V. It is updated on the same edge as V, so reads reflect post-edge state.
- Reset, asynchronous and at any time, including mid-stall:
  - V[i]=0 and D[i]=RESET_DATA.
  - OutValid=0, OutData=RESET_DATA, Occupancy=0, StallCount=0.
  - After release, InReady=1 combinationally.
- InValid=1 with InReady=0: the word is not captured, and upstream must hold it.
- DEPTH=1 degenerates to a single skid-less register with handshake.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - StallCount increments on each posedge where OutValid=1 && OutReady=0 && Flush=0.
  - It saturates at 32'hFFFF_FFFF and clears on Reset.
- Undefined:
  - StallCount is tied to 0.
  - No counter flops are inferred.
  - The port remains present so instantiations are identical.

Decomposition:
- Shared package pipe_pkg holds:
  - localparam OCC_W = 3.
  - localparam STALL_CNT_W = 32.
  - typedef for a default 32-bit payload word.
  - MEM/WB field offset constants (RegWrite, MemtoReg, Branch, ReadData, ALUResult, DestReg) so callers pack consistently.
- One natural sub-module is pipe_stage_slot: a single V/D stage with load and flush inputs, generated DEPTH times.
- Handshake chain, occupancy and perf counter stay in the top.

Test Plan:
- Reset and stream: DEPTH=3, WIDTH=32.
  - Stimulus: assert Reset mid-run, release, then drive InValid=1 with InData=1,2,3,4 on consecutive cycles and OutReady=1.
  - Required: OutValid first rises 3 cycles after the first accept; OutData=1,2,3,4 back-to-back; Occupancy peaks at 3.
- Back-pressure: DEPTH=3.
  - Stimulus: OutReady=0 for 5 cycles with continuous input 0xA0..0xA4.
  - Required: InReady drops after 3 accepts; OutData holds 0xA0; on OutReady=1, 0xA0..0xA4 exit in order with no loss or duplication.
- Bubble collapse: DEPTH=3.
  - Stimulus: V pattern {1,0,1} (stage 0..2) with OutReady=0.
  - Required: the stage-0 word moves to stage 1 next edge; InReady=1 that cycle; Occupancy stays 2.
- Flush priority:
  - Stimulus: pipe full (0x11, 0x22, 0x33); assert Flush with InValid=1, InData=0x44.
  - Required: next cycle OutValid=0, Occupancy=0, and 0x44 never appears at the output.
- Async reset mid-stall:
  - Stimulus: pipe full and stalled; pulse Reset between clock edges.
  - Required: OutValid=0 and OutData=RESET_DATA immediately, without waiting for a clock edge.
- Perf counter:
  - With PIPE_STAGE_PERF_EN: 7 stall cycles, a 1-cycle Flush, then 2 more stall cycles → StallCount=9.
  - Without the macro: the same stimulus → StallCount=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register (pipe_stage_reg).
// Holds the widths of the status outputs and a default payload word type.
// It also holds the MEM/WB field layout, so every caller packs and unpacks
// that payload the same way.
package pipe_pkg;

    // Status output widths
    localparam int unsigned OCC_W       = 3;
    localparam int unsigned STALL_CNT_W = 32;

    // Default payload word
    localparam int unsigned WORD_W = 32;
    typedef logic [WORD_W-1:0] pipe_word_t;

    // MEM/WB payload layout (bit offsets within the packed stage word)
    localparam int unsigned MEMWB_DEST_REG_LSB   = 0;
    localparam int unsigned MEMWB_DEST_REG_W     = 5;
    localparam int unsigned MEMWB_ALU_RESULT_LSB = 5;
    localparam int unsigned MEMWB_ALU_RESULT_W   = 32;
    localparam int unsigned MEMWB_READ_DATA_LSB  = 37;
    localparam int unsigned MEMWB_READ_DATA_W    = 32;
    localparam int unsigned MEMWB_BRANCH_BIT     = 69;
    localparam int unsigned MEMWB_MEM_TO_REG_BIT = 70;
    localparam int unsigned MEMWB_REG_WRITE_BIT  = 71;
    localparam int unsigned MEMWB_W              = 72;

    // MEM/WB fields as seen by the surrounding pipeline stages
    typedef struct packed {
        logic                          reg_write;
        logic                          mem_to_reg;
        logic                          branch;
        logic [MEMWB_READ_DATA_W-1:0]  read_data;
        logic [MEMWB_ALU_RESULT_W-1:0] alu_result;
        logic [MEMWB_DEST_REG_W-1:0]   dest_reg;
    } memwb_t;

    // Pack MEM/WB fields into a flat stage word using the offsets above
    function automatic logic [MEMWB_W-1:0] pack_memwb(input memwb_t f);
        logic [MEMWB_W-1:0] w;
        w = '0;
        w[MEMWB_DEST_REG_LSB   +: MEMWB_DEST_REG_W]   = f.dest_reg;
        w[MEMWB_ALU_RESULT_LSB +: MEMWB_ALU_RESULT_W] = f.alu_result;
        w[MEMWB_READ_DATA_LSB  +: MEMWB_READ_DATA_W]  = f.read_data;
        w[MEMWB_BRANCH_BIT]                           = f.branch;
        w[MEMWB_MEM_TO_REG_BIT]                       = f.mem_to_reg;
        w[MEMWB_REG_WRITE_BIT]                        = f.reg_write;
        return w;
    endfunction

    // Recover MEM/WB fields from a flat stage word
    function automatic memwb_t unpack_memwb(input logic [MEMWB_W-1:0] w);
        memwb_t f;
        f.dest_reg   = w[MEMWB_DEST_REG_LSB   +: MEMWB_DEST_REG_W];
        f.alu_result = w[MEMWB_ALU_RESULT_LSB +: MEMWB_ALU_RESULT_W];
        f.read_data  = w[MEMWB_READ_DATA_LSB  +: MEMWB_READ_DATA_W];
        f.branch     = w[MEMWB_BRANCH_BIT];
        f.mem_to_reg = w[MEMWB_MEM_TO_REG_BIT];
        f.reg_write  = w[MEMWB_REG_WRITE_BIT];
        return f;
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One valid/data register stage of pipe_stage_reg.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   advance         stage may take its predecessor's contents this edge
//   flush           squash: clear valid, keep data
//   prev_valid/data predecessor stage (or upstream input for stage 0)
//   valid/data      registered stage contents
//   valid_next_c    combinational next value of valid (feeds occupancy)
module pipe_stage_slot #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             flush,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             valid_next_c
);

    // Next valid: flush wins, otherwise take predecessor when advancing
    always_comb begin
        valid_next_c = valid;
        if (flush) begin
            valid_next_c = 1'b0;
        end else if (advance) begin
            valid_next_c = prev_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
        end else begin
            valid <= valid_next_c;
        end
    end

    // Data loads only with a real incoming word, so bubbles cause no toggling
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= RESET_DATA;
        end else if (advance && prev_valid && !flush) begin
            data <= prev_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic, parametrised pipeline register: DEPTH valid/data stages with a
// valid/ready handshake, bubble collapse and a synchronous flush.
// Optional stall counter is enabled by defining PIPE_STAGE_PERF_EN.
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   InValid/InReady     upstream handshake (InReady is combinational)
//   InData              upstream payload
//   Flush               squash all in-flight words on the next edge
//   OutValid/OutReady   downstream handshake (OutValid registered)
//   OutData             last-stage payload (registered)
//   Occupancy           registered count of valid stages
//   StallCount          cycles with OutValid && !OutReady (0 when disabled)
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      DEPTH      = 1,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   InValid,
    output logic                   InReady,
    input  logic [WIDTH-1:0]       InData,
    input  logic                   Flush,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [WIDTH-1:0]       OutData,
    output logic [OCC_W-1:0]       Occupancy,
    output logic [STALL_CNT_W-1:0] StallCount
);

    // Chain index 0 is the upstream input; index i+1 is stage i
    logic [DEPTH:0]   chain_valid;
    logic [WIDTH-1:0] chain_data [DEPTH+1];
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] valid_next;
    logic [OCC_W-1:0] occ_next;

    assign chain_valid[0] = InValid;
    assign chain_data[0]  = InData;

    // Ready ripples back from OutReady; an empty stage is always ready
    always_comb begin : ready_chain
        logic ready_acc;
        adv            = '0;
        ready_acc      = OutReady || !chain_valid[DEPTH];
        adv[DEPTH-1]   = ready_acc;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            ready_acc = ready_acc || !chain_valid[i+1];
            adv[i]    = ready_acc;
        end
    end

    // Flush does not gate InReady: upstream sees its word consumed
    assign InReady = adv[0];

    // Register stages
    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_stage
        pipe_stage_slot #(
            .WIDTH      (WIDTH),
            .RESET_DATA (RESET_DATA)
        ) u_slot (
            .clk          (Clk),
            .rst          (Reset),
            .advance      (adv[g]),
            .flush        (Flush),
            .prev_valid   (chain_valid[g]),
            .prev_data    (chain_data[g]),
            .valid        (chain_valid[g+1]),
            .data         (chain_data[g+1]),
            .valid_next_c (valid_next[g])
        );
    end

    assign OutValid = chain_valid[DEPTH];
    assign OutData  = chain_data[DEPTH];

    // Occupancy tracks the post-edge valid bits
    always_comb begin
        occ_next = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            occ_next = occ_next + OCC_W'(valid_next[i]);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Occupancy <= '0;
        end else begin
            Occupancy <= occ_next;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Saturating stall counter; flush cycles are not counted as stalls
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            StallCount <= '0;
        end else if (OutValid && !OutReady && !Flush && (StallCount != '1)) begin
            StallCount <= StallCount + STALL_CNT_W'(1);
        end
    end
`else
    assign StallCount = '0;
`endif

endmodule
